// File: rtl/dff_arb_pkg.sv
// Shared definitions for the round-robin register-load arbiter: FSM state encoding and grant helpers.
package dff_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    // Largest requester count the one-hot helper can encode.
    localparam int MAX_REQ = 32;

    typedef enum logic {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT
    } state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward, wrapping at N_REQ.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     valid
);
    localparam int PW = $clog2(N_REQ);

    int unsigned idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Optional ARB_LOCK_EN adds a lock port that holds the grant and reloads Q on every edge.
module dff_bank_arbiter #(
    parameter int               N_REQ   = 4,
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     RSTN,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   din,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0]         lock,
`endif
    output logic [N_REQ-1:0]         gnt,
    output logic                     ack,
    output logic [WIDTH-1:0]         Q,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy
);
    import dff_arb_pkg::*;

    localparam int PW = $clog2(N_REQ);

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    pick;
    logic             pick_vld;
    logic [PW-1:0]    ptr_nxt;
    logic [WIDTH-1:0] slice;
    logic             hold;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_vld)
    );

    assign ptr_nxt = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign slice   = din[int'(owner)*WIDTH +: WIDTH];

`ifdef ARB_LOCK_EN
    assign hold = lock[owner];
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            gnt   <= '0;
            ack   <= 1'b0;
            Q     <= RST_VAL;
            owner <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt   <= N_REQ'(onehot(int'(pick)));
                        owner <= pick;
                        state <= GRANT;
                        busy  <= 1'b1;
                    end else begin
                        gnt <= '0;
                    end
                end
                GRANT: begin
                    if (req[owner]) begin
                        Q   <= slice;
                        ack <= 1'b1;
                        // A locked owner keeps the port; priority only rotates once it lets go.
                        if (!hold) begin
                            ptr   <= ptr_nxt;
                            state <= IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed testbench for dff_bank_arbiter (N_REQ=4, WIDTH=8); lock scenario built only with ARB_LOCK_EN.
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic [31:0] din;
`ifdef ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [3:0]  gnt;
    logic        ack;
    logic [7:0]  Q;
    logic [1:0]  owner;
    logic        busy;

    int total = 0;
    int bad   = 0;

    dff_bank_arbiter #(.N_REQ(4), .WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk   (clk),
        .RSTN  (rstn),
        .req   (req),
        .din   (din),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .ack   (ack),
        .Q     (Q),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        req  = '0;
        din  = '0;
`ifdef ARB_LOCK_EN
        lock = '0;
`endif
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({gnt, ack, Q, owner, busy} !== {4'b0000, 1'b0, 8'h00, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state gnt=%b ack=%b Q=%h owner=%0d busy=%b exp all zero", gnt, ack, Q, owner, busy);
        end
        req = 4'b1111;
        din = 32'h44332211;
        tick();
        tick();
        total++;
        if ({ack, Q} !== {1'b1, 8'h11}) begin
            bad++;
            $display("FAIL reset_preload ack=%b Q=%h exp ack=1 Q=11", ack, Q);
        end
        tick();
        #3 rstn = 1'b0;
        #1;
        total++;
        if ({gnt, ack, Q, busy, owner} !== {4'b0000, 1'b0, 8'h00, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL reset_async gnt=%b ack=%b Q=%h busy=%b owner=%0d exp 0/0/00/0/0", gnt, ack, Q, busy, owner);
        end
        req = '0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0100;
        din = 32'h00A50000;
        tick();
        total++;
        if ({gnt, ack, owner, busy} !== {4'b0100, 1'b0, 2'd2, 1'b1}) begin
            bad++;
            $display("FAIL single_edge1 gnt=%b ack=%b owner=%0d busy=%b exp 0100/0/2/1", gnt, ack, owner, busy);
        end
        tick();
        total++;
        if ({gnt, ack, Q} !== {4'b0000, 1'b1, 8'hA5}) begin
            bad++;
            $display("FAIL single_edge2 gnt=%b ack=%b Q=%h exp 0000/1/A5", gnt, ack, Q);
        end
        req = '0;
        tick();
        total++;
        if ({gnt, ack, busy, Q} !== {4'b0000, 1'b0, 1'b0, 8'hA5}) begin
            bad++;
            $display("FAIL single_edge3 gnt=%b ack=%b busy=%b Q=%h exp 0000/0/0/A5", gnt, ack, busy, Q);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [7:0] eq;
        apply_reset();
        req = 4'b1111;
        din = 32'h44332211;
        for (int i = 0; i < 5; i++) begin
            eg = 4'b0001 << (i % 4);
            eq = 8'h11 * 8'((i % 4) + 1);
            tick();
            total++;
            if ({gnt, ack} !== {eg, 1'b0}) begin
                bad++;
                $display("FAIL rr_grant%0d gnt=%b ack=%b exp %b/0", i, gnt, ack, eg);
            end
            tick();
            total++;
            if ({ack, Q, gnt} !== {1'b1, eq, 4'b0000}) begin
                bad++;
                $display("FAIL rr_load%0d ack=%b Q=%h gnt=%b exp 1/%h/0000", i, ack, Q, gnt, eq);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_cancel();
        apply_reset();
        req = 4'b0001;
        din = 32'h0000005A;
        tick();
        tick();
        req = 4'b0010;
        din = 32'h0000EE5A;
        tick();
        total++;
        if ({gnt, owner} !== {4'b0010, 2'd1}) begin
            bad++;
            $display("FAIL cancel_grant gnt=%b owner=%0d exp 0010/1", gnt, owner);
        end
        req = '0;
        tick();
        total++;
        if ({gnt, ack, Q, busy} !== {4'b0000, 1'b0, 8'h5A, 1'b0}) begin
            bad++;
            $display("FAIL cancel_drop gnt=%b ack=%b Q=%h busy=%b exp 0000/0/5A/0", gnt, ack, Q, busy);
        end
        req = 4'b1111;
        tick();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL cancel_ptr gnt=%b exp 0010", gnt);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_in_grant();
        apply_reset();
        req = 4'b1000;
        din = 32'h77000000;
        tick();
        total++;
        if (gnt !== 4'b1000) begin
            bad++;
            $display("FAIL rstg_grant gnt=%b exp 1000", gnt);
        end
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({gnt, busy} !== {4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL rstg_async gnt=%b busy=%b exp 0000/0", gnt, busy);
        end
        tick();
        total++;
        if ({ack, Q} !== {1'b0, 8'h00}) begin
            bad++;
            $display("FAIL rstg_noload ack=%b Q=%h exp 0/00", ack, Q);
        end
        rstn = 1'b1;
        req  = 4'b1001;
        tick();
        total++;
        if ({gnt, owner} !== {4'b0001, 2'd0}) begin
            bad++;
            $display("FAIL rstg_after gnt=%b owner=%0d exp 0001/0", gnt, owner);
        end
        req = '0;
        tick();
        tick();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        req  = 4'b1000;
        lock = 4'b1000;
        din  = 32'h01000000;
        tick();
        total++;
        if (gnt !== 4'b1000) begin
            bad++;
            $display("FAIL lock_grant gnt=%b exp 1000", gnt);
        end
        tick();
        total++;
        if ({ack, Q, gnt} !== {1'b1, 8'h01, 4'b1000}) begin
            bad++;
            $display("FAIL lock_load1 ack=%b Q=%h gnt=%b exp 1/01/1000", ack, Q, gnt);
        end
        din = 32'h02000000;
        tick();
        total++;
        if ({ack, Q, gnt} !== {1'b1, 8'h02, 4'b1000}) begin
            bad++;
            $display("FAIL lock_load2 ack=%b Q=%h gnt=%b exp 1/02/1000", ack, Q, gnt);
        end
        din  = 32'h03000000;
        lock = 4'b0000;
        req  = 4'b1001;
        tick();
        total++;
        if ({ack, Q, gnt} !== {1'b1, 8'h03, 4'b0000}) begin
            bad++;
            $display("FAIL lock_load3 ack=%b Q=%h gnt=%b exp 1/03/0000", ack, Q, gnt);
        end
        req = 4'b0001;
        tick();
        total++;
        if ({gnt, ack} !== {4'b0001, 1'b0}) begin
            bad++;
            $display("FAIL lock_next gnt=%b ack=%b exp 0001/0", gnt, ack);
        end
        req = '0;
        tick();
        tick();
    endtask
`endif

    initial begin
        rstn = 1'b0;
        req  = '0;
        din  = '0;
`ifdef ARB_LOCK_EN
        lock = '0;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_cancel();
        test_reset_in_grant();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
